// File: rtl/iter_cnt_pkg.sv
// iter_cnt_pkg: shared state encoding and default terminal for iter_step_counter.
package iter_cnt_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
  function automatic int term_max(input int w);
    return (1 << w) - 1;
  endfunction
endpackage

// File: rtl/iter_step_counter.sv
// iter_step_counter: start/busy/done step sequencer counting term+1 en-qualified steps.
// Optional abort input enabled by defining ITER_CNT_ABORT_EN.
module iter_step_counter
  import iter_cnt_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int TERM_RST = term_max(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] term_in,
  input  logic             en,
`ifdef ITER_CNT_ABORT_EN
  input  logic             abort,
`endif
  output logic [WIDTH-1:0] count,
  output logic             first,
  output logic             last,
  output logic             busy,
  output logic             done
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d, term_q, term_d;
  logic             accept, abort_hit;
  assign accept = start && state_q != S_RUN;
`ifdef ITER_CNT_ABORT_EN
  assign abort_hit = abort && state_q == S_RUN;
`else
  assign abort_hit = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    term_d  = term_q;
    if (accept) begin
      term_d  = term_in;
      count_d = '0;
      state_d = S_RUN;
    end else if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end else if (abort_hit) begin
      state_d = S_IDLE;
      count_d = '0;
    end else if (state_q == S_RUN && en) begin
      state_d = count_q == term_q ? S_DONE : S_RUN;
      count_d = count_q == term_q ? count_q : count_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      term_q  <= WIDTH'(TERM_RST);
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      term_q  <= term_d;
    end
  end
  assign count = count_q;
  assign busy  = state_q == S_RUN;
  assign done  = state_q == S_DONE;
  assign first = busy && count_q == '0;
  assign last  = busy && count_q == term_q;
endmodule

// File: doc/iter_step_counter.md
# iter_step_counter

Parametrised iteration sequencer for the multi-cycle arithmetic units (restoring divider, shift-add multiplier). It counts a programmable number of steps, term+1 in total. Each run opens with a start handshake and ends with a one-cycle done pulse. It replaces the fixed 3-bit free-running step counter with a registered-terminal, start/busy/done controlled block that the datapath FSMs drive directly.

## Interface
Parameters:
- WIDTH, 3, width of count and terminal value.
- TERM_RST, 2**WIDTH-1, terminal value held in the term register after reset.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE or DONE.
- term_in  in  WIDTH  last step index; captured on an accepted start.
- en  in  1  advance one step when high in RUN.
- count  out  WIDTH  current step index, 0..term.
- first  out  1  busy && count==0; combinational.
- last  out  1  busy && count==term; combinational.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after the final step.
- abort  in  1  present only with ITER_CNT_ABORT_EN.

## Operation
- The FSM has three states: S_IDLE, S_RUN and S_DONE.
- **S_IDLE:** busy=0. An accepted start sets term<=term_in and count<=0, then moves to S_RUN.
- **S_RUN, en=1, count!=term:** count<=count+1.
- **S_RUN, en=1, count==term:** count holds at term, then move to S_DONE.
- **S_RUN, en=0:** all state holds.
- **S_DONE:** done=1 for exactly one cycle.
  - Next state is S_IDLE.
  - If start is high, an accepted start behaves as in S_IDLE (back-to-back run, no idle gap).
- **start outside S_IDLE/S_DONE:** ignored while in S_RUN; term and count are unaffected.
- **term_in=0:** valid. The run takes one en step; first and last are both high in that step.
- **Width rule:** count never exceeds term. term ≤ 2**WIDTH-1, so no wrap-around is possible.
- **Enable:** en is ignored outside S_RUN.

## Timing
- **Reset values:** count=0, term=TERM_RST, state=S_IDLE, busy=0, done=0, first=0, last=0.
- **rst:** rst high at any edge, including mid-run, forces the reset values. No done pulse is produced.
- **Run latency:** start accepted at edge 0 gives busy=1 and count=0 after that edge.
- **Run length with en held high:**
  - last is high in cycle term+1.
  - done is high in cycle term+2; busy is low in that cycle.
- **Total:** term+1 en-qualified steps; latency start→done is term+2 cycles minimum.
- **Back-to-back:** start during the done cycle gives busy=1 on the following cycle.
- **Output timing:** done, busy and count are registered; first and last are decoded from registered state only.

## Configuration
- ITER_CNT_ABORT_EN defined:
  - Adds the abort input.
  - abort high in S_RUN → next state S_IDLE, count<=0, no done pulse.
  - abort in S_IDLE or S_DONE is ignored.
  - abort and start in the same cycle in S_DONE: abort has no effect, start is accepted.
- Not defined: abort port absent; a run can only end normally or via rst.

## Structure
- **Shared package iter_cnt_pkg:**
  - typedef enum state_e {S_IDLE, S_RUN, S_DONE}.
  - Localparam function for the default TERM_RST.
- **Sub-modules:** none; a single module is natural. The term register, count register and FSM are kept in one file.

## Test plan
- **Reset:** rst=1 for 2 cycles → count=0, busy=0, done=0, first=0, last=0; term reads back as 7 (WIDTH=3).
- **Full run:** start with term_in=7, en held 1 → count 0..7 on cycles 1..8, first in cycle 1, last in cycle 8, done in cycle 9 only.
- **Gated enable:** term_in=3, en toggling 1,0,1,0… → count advances only on en cycles; done exactly 1 cycle after the 4th en step. A start pulse mid-run is ignored.
- **Single step and back-to-back:** term_in=0 → first=last=1 in cycle 1, done in cycle 2. start during done with term_in=2 → busy=1 next cycle, count restarts at 0.
- **Mid-run reset:** rst asserted at count=4 → all outputs reset next cycle, no done pulse.
- **Abort (ITER_CNT_ABORT_EN):** abort at count=2 → S_IDLE, count=0, done never asserted.
